data_bus_adapter: RTL
=====================

Name: data_bus_adapter

Overview:
- Sits directly downstream of the memory stage's SRAM-style port (mem_en / mem_wen / mem_addr / mem_wdata / mem_rdata).
- Converts each single-cycle SRAM access into a two-phase request/response bus transaction (addr_ok, then data_ok) with variable latency.
- Stalls the pipeline until the access completes, then holds read data stable until the memory stage advances.
- Handles pipeline flush and a bus-timeout watchdog.

Parameters:
- TIMEOUT_CYCLES, 255, cycles to wait in ADDR or DATA before forcing a bus error; range 1..65535.
- TMR_W, 16, watchdog counter width; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- mem_en  in  1  access request from memory stage
- mem_wen  in  4  byte write strobes; 0 means load
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data, already lane-replicated
- mem_rdata  out  32  load data to memory stage
- pipe_advance  in  1  memory-stage instruction leaves the stage this cycle
- flush  in  1  exception/flush; current memory-stage instruction is cancelled
- stall  out  1  memory stage must hold
- bus_error  out  1  one-cycle pulse on watchdog expiry
- bus_req  out  1  transaction request
- bus_wr  out  1  1 = write
- bus_wstrb  out  4  write strobes
- bus_addr  out  32  word-aligned address ({mem_addr[31:2],2'b00})
- bus_wdata  out  32  write data
- bus_addr_ok  in  1  request accepted (handshake when bus_req && bus_addr_ok)
- bus_data_ok  in  1  response valid; one per accepted request, in order
- bus_rdata  in  32  read data, valid with bus_data_ok

Behaviour:
- Reset: state = IDLE, discard = 0, timer = 0. Outputs on reset: bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, mem_rdata, bus_error all 0; stall = mem_en (combinational).
- Bus outputs are registered. The captured request (wr, wstrb, addr, wdata) is held constant from capture until the addr_ok handshake.

State machine, IDLE / ADDR / DATA / DONE:
- IDLE: if mem_en && !flush, capture the request, set bus_req = 1, go to ADDR. Otherwise stay.
- ADDR, handshake this cycle: bus_req = 0 next cycle; go to DATA; timer = 0.
- ADDR, flush without handshake: abandon the request; bus_req = 0; go to IDLE.
- ADDR, flush together with handshake: go to DATA with discard = 1.
- DATA, bus_data_ok with discard = 0: latch mem_rdata = bus_rdata for a load, 0 for a store; go to DONE.
- DATA, bus_data_ok with discard = 1: go to IDLE, clear discard, leave mem_rdata unchanged.
- DATA, flush without bus_data_ok: set discard = 1 and stay in DATA.
- DONE: mem_rdata is held. On pipe_advance or flush, go to IDLE.
- Watchdog: timer increments each cycle in ADDR or DATA and clears on any state change.
  - When timer reaches TIMEOUT_CYCLES - 1 without the awaited handshake: bus_error pulses for exactly one cycle next clock, bus_req drops, mem_rdata = 0, and the next state is DONE (or IDLE if discard or flush).
  - A late bus_data_ok that arrives in IDLE after a timeout is ignored.

stall (combinational):
- stall = (mem_en && state != DONE) || (state == DATA && discard). In the second case a new request is blocked until the drain finishes.
- In the flush cycle, stall = 0 unless draining.

Latency:
- Minimum load, with addr_ok in the first ADDR cycle and data_ok in the next: request cycle T, ADDR T+1, DATA T+2, DONE T+3.
- stall is high in cycles T..T+2 and low at T+3, with mem_rdata valid from T+3.

Other rules:
- Back-to-back accesses: the request presented in the same cycle as pipe_advance in DONE is not captured. It is captured on the next IDLE cycle.
- bus_data_ok or bus_addr_ok arriving in a state that does not expect it is ignored.
- Reset mid-transaction returns to IDLE immediately. The bus side is assumed reset together.

Test Plan:
- Load: mem_en=1, mem_wen=0, mem_addr=0x1000_0006; addr_ok in the 1st ADDR cycle, data_ok 2 cycles later with 0xDEAD_BEEF -> bus_addr=0x1000_0004, bus_wr=0, stall high 4 cycles, then mem_rdata=0xDEAD_BEEF with stall=0 until pipe_advance.
- Store: mem_wen=4'b1100, mem_wdata=0x1234_1234 -> bus_wr=1, bus_wstrb=4'b1100, bus_wdata=0x1234_1234; mem_rdata=0 in DONE.
- Back-pressure: addr_ok held low 5 cycles -> bus_req and payload stable all 5 cycles, exactly one handshake.
- Flush in DATA: flush one cycle after the handshake, new mem_en presented -> stall stays high until data_ok; then returns to IDLE with mem_rdata unchanged; the next request is issued afterwards.
- Flush in ADDR before addr_ok -> bus_req low next cycle, state IDLE, no bus_error.
- Timeout with TIMEOUT_CYCLES=8: data_ok never arrives -> bus_error single pulse 8 cycles after entering DATA, mem_rdata=0, stall released; a late data_ok is ignored.

Source files
------------

// File: rtl/data_bus_adapter.sv
// Adapts a single-cycle SRAM-style access to a two-phase addr_ok/data_ok bus transaction.
// Latency: request cycle T, ADDR T+1, DATA T+2, DONE T+3 at minimum; otherwise it depends on the bus.
// Backpressure: stall holds the memory stage until the response is latched or a flushed response is drained.
module data_bus_adapter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMR_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic        pipe_advance,
  input  logic        flush,
  output logic        stall,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  // Last timer value before the watchdog gives up on the awaited handshake.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic              discard;
  logic              discard_nxt;
  logic [TMR_W-1:0]  timer;
  logic              tmr_hit;
  logic              capture;
  logic              rd_latch;
  logic              tmo;
  logic              addr_hs;

  // The byte offset is dropped: the bus only sees word-aligned addresses.
  logic              unused_addr_lsb;
  assign unused_addr_lsb = ^mem_addr[1:0];

  assign tmr_hit = (timer == TMR_LAST);
  assign addr_hs = bus_req && bus_addr_ok;

  // Hold the memory stage while its access is outstanding, and also while a
  // cancelled access's response is still owed by the bus.
  assign stall = (mem_en && !flush && (state != DONE)) || ((state == DATA) && discard);

  // State register with the drain flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
    end
  end

  // Next-state logic; also decides when to capture, latch read data or time out.
  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    capture     = 1'b0;
    rd_latch    = 1'b0;
    tmo         = 1'b0;
    case (state)
      IDLE: begin
        if (mem_en && !flush) begin
          capture   = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (addr_hs) begin
          // Once accepted the response must still be consumed, even if flushed.
          state_nxt   = DATA;
          discard_nxt = flush;
        end else if (tmr_hit) begin
          tmo       = 1'b1;
          state_nxt = flush ? IDLE : DONE;
        end else if (flush) begin
          state_nxt = IDLE;
        end
      end
      DATA: begin
        if (bus_data_ok) begin
          if (discard || flush) begin
            state_nxt   = IDLE;
            discard_nxt = 1'b0;
          end else begin
            rd_latch  = 1'b1;
            state_nxt = DONE;
          end
        end else if (tmr_hit) begin
          tmo         = 1'b1;
          state_nxt   = (discard || flush) ? IDLE : DONE;
          discard_nxt = 1'b0;
        end else if (flush) begin
          discard_nxt = 1'b1;
        end
      end
      DONE: begin
        if (pipe_advance || flush) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        discard_nxt = 1'b0;
      end
    endcase
  end

  // Watchdog: counts cycles spent waiting in ADDR or DATA, restarts on any state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if ((state_nxt != state) || !((state == ADDR) || (state == DATA))) begin
      timer <= '0;
    end else begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Registered bus request and payload; payload is frozen from capture through the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_wstrb <= 4'b0000;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
    end else begin
      bus_req <= (state_nxt == ADDR);
      if (capture) begin
        bus_wr    <= |mem_wen;
        bus_wstrb <= mem_wen;
        bus_addr  <= {mem_addr[31:2], 2'b00};
        bus_wdata <= mem_wdata;
      end
    end
  end

  // Load data returned to the memory stage, and the single-cycle error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rdata <= 32'h0;
      bus_error <= 1'b0;
    end else begin
      bus_error <= tmo;
      if (rd_latch) begin
        mem_rdata <= bus_wr ? 32'h0 : bus_rdata;
      end else if (tmo) begin
        mem_rdata <= 32'h0;
      end
    end
  end

endmodule
